// File: rtl/plab4_net_sd_pkg.sv
// rtl/plab4_net_sd_pkg.sv - shared types and constants for the security-domain scheduler
package plab4_net_sd_pkg;

  // ACTIVE lets the current domain inject; DEAD blocks injection while the ring drains
  typedef enum logic {
    SD_ACTIVE = 1'b0,
    SD_DEAD   = 1'b1
  } sd_state_e;

  // Security domain identifier carried by terminals and routers
  typedef logic sd_t;

  localparam int unsigned SD_DEF_CNT_NBITS   = 8;
  localparam int unsigned SD_DEF_EPOCH_LEN_0 = 16;
  localparam int unsigned SD_DEF_EPOCH_LEN_1 = 16;
  localparam int unsigned SD_DEF_DEAD_CYCLES = 4;

  // A zero-length epoch would never end, so it is treated as one cycle
  function automatic int unsigned sd_clamp_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/plab4_net_sd_epoch_ctr.sv
// rtl/plab4_net_sd_epoch_ctr.sv - loadable down-counter with terminal-count flag
module plab4_net_sd_epoch_ctr #(
  parameter int unsigned                p_cnt_nbits = 8,
  parameter logic [p_cnt_nbits-1:0]     p_rst_val   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic [p_cnt_nbits-1:0] load_val_i,
  output logic [p_cnt_nbits-1:0] cnt_o,
  output logic                   tc_o
);

  logic [p_cnt_nbits-1:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= p_rst_val;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/plab4_net_sd_scheduler.sv
// rtl/plab4_net_sd_scheduler.sv - time-division domain scheduler for the ring; PLAB4_NET_SD_SCHED_CFG_EN adds runtime epoch lengths
module plab4_net_sd_scheduler
  import plab4_net_sd_pkg::*;
#(
  parameter int unsigned p_cnt_nbits   = SD_DEF_CNT_NBITS,
  parameter int unsigned p_epoch_len_0 = SD_DEF_EPOCH_LEN_0,
  parameter int unsigned p_epoch_len_1 = SD_DEF_EPOCH_LEN_1,
  parameter int unsigned p_dead_cycles = SD_DEF_DEAD_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef PLAB4_NET_SD_SCHED_CFG_EN
  input  logic                   cfg_val,
  input  sd_t                    cfg_sd,
  input  logic [p_cnt_nbits-1:0] cfg_len,
  output logic                   cfg_rdy,
`endif
  input  logic [3:0]             in_sd,
  output logic                   cur_sd,
  output logic [3:0]             inj_allow,
  output logic                   phase,
  output logic                   epoch_start
);

  localparam logic [p_cnt_nbits-1:0] LEN0_RAW  = p_cnt_nbits'(p_epoch_len_0);
  localparam logic [p_cnt_nbits-1:0] LEN1_RAW  = p_cnt_nbits'(p_epoch_len_1);
  localparam logic [p_cnt_nbits-1:0] LEN0      = p_cnt_nbits'(sd_clamp_len(p_epoch_len_0));
  localparam logic [p_cnt_nbits-1:0] LEN0_LAST = LEN0 - 1'b1;
  localparam logic [p_cnt_nbits-1:0] DEAD_LAST =
    p_cnt_nbits'((p_dead_cycles > 0) ? (p_dead_cycles - 1) : 0);

  sd_state_e              state_q;
  logic                   cur_sd_q;
  logic [p_cnt_nbits-1:0] len_q;
  logic                   phase_q;
  logic                   epoch_start_q;

  logic [p_cnt_nbits-1:0] raw_len_next;
  logic [p_cnt_nbits-1:0] len_next;
  logic                   ctr_load;
  logic [p_cnt_nbits-1:0] ctr_val;
  logic [p_cnt_nbits-1:0] ctr_cnt;
  logic                   ctr_tc;

`ifdef PLAB4_NET_SD_SCHED_CFG_EN
  logic [p_cnt_nbits-1:0] shadow0_q;
  logic [p_cnt_nbits-1:0] shadow1_q;

  assign cfg_rdy = 1'b1;

  // Shadow lengths accept writes at any time; they only matter at the next entry of their domain
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow0_q <= LEN0_RAW;
      shadow1_q <= LEN1_RAW;
    end else if (cfg_val && cfg_rdy) begin
      if (cfg_sd) shadow1_q <= cfg_len;
      else        shadow0_q <= cfg_len;
    end
  end

  // The next epoch belongs to the other domain; pre-edge shadow value is used
  assign raw_len_next = cur_sd_q ? shadow0_q : shadow1_q;
`else
  // The next epoch belongs to the other domain
  assign raw_len_next = cur_sd_q ? LEN0_RAW : LEN1_RAW;
`endif

  assign len_next = (raw_len_next == '0) ? {{(p_cnt_nbits-1){1'b0}}, 1'b1} : raw_len_next;

  // Reload the shared counter for the dead window or for the next epoch at each phase end
  always_comb begin
    ctr_load = 1'b0;
    ctr_val  = len_next - 1'b1;
    if (ctr_tc) begin
      ctr_load = 1'b1;
      if ((state_q == SD_ACTIVE) && (p_dead_cycles > 0)) ctr_val = DEAD_LAST;
      else                                                ctr_val = len_next - 1'b1;
    end
  end

  plab4_net_sd_epoch_ctr #(
    .p_cnt_nbits (p_cnt_nbits),
    .p_rst_val   (LEN0_LAST)
  ) epoch_ctr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ctr_load),
    .load_val_i (ctr_val),
    .cnt_o      (ctr_cnt),
    .tc_o       (ctr_tc)
  );

  // Phase sequencing; the domain flips only when entering ACTIVE, never on leaving it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SD_ACTIVE;
      cur_sd_q      <= 1'b0;
      len_q         <= LEN0;
      phase_q       <= 1'b0;
      epoch_start_q <= 1'b1;
    end else begin
      epoch_start_q <= 1'b0;
      if (ctr_tc) begin
        if ((state_q == SD_ACTIVE) && (p_dead_cycles > 0)) begin
          state_q <= SD_DEAD;
          phase_q <= 1'b1;
        end else begin
          state_q       <= SD_ACTIVE;
          phase_q       <= 1'b0;
          cur_sd_q      <= ~cur_sd_q;
          len_q         <= len_next;
          epoch_start_q <= 1'b1;
        end
      end
    end
  end

  // The remaining count in an epoch always stays below the latched length
  assert property (@(posedge clk) disable iff (reset)
    (state_q == SD_ACTIVE) |-> (ctr_cnt < len_q));

  assign cur_sd      = cur_sd_q;
  assign phase       = phase_q;
  assign epoch_start = epoch_start_q;
  assign inj_allow   = (state_q == SD_ACTIVE) ? ~(in_sd ^ {4{cur_sd_q}}) : 4'b0000;

endmodule

// File: tb/tb_plab4_net_sd_scheduler.sv
// tb/tb_plab4_net_sd_scheduler.sv - directed vector bench for the domain scheduler
module tb_plab4_net_sd_scheduler;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] in_sd_a, in_sd_b;
  logic       cur_sd_a, cur_sd_b;
  logic [3:0] inj_a, inj_b;
  logic       phase_a, phase_b;
  logic       es_a, es_b;
  logic       cfg_val;
  logic       cfg_sd;
  logic [7:0] cfg_len;
`ifdef PLAB4_NET_SD_SCHED_CFG_EN
  logic       cfg_rdy_a, cfg_rdy_b;
`endif

  always #5 clk = ~clk;

  plab4_net_sd_scheduler #(
    .p_cnt_nbits(8), .p_epoch_len_0(4), .p_epoch_len_1(6), .p_dead_cycles(2)
  ) dut_a (
    .clk(clk), .reset(rst_a),
`ifdef PLAB4_NET_SD_SCHED_CFG_EN
    .cfg_val(cfg_val), .cfg_sd(cfg_sd), .cfg_len(cfg_len), .cfg_rdy(cfg_rdy_a),
`endif
    .in_sd(in_sd_a), .cur_sd(cur_sd_a), .inj_allow(inj_a),
    .phase(phase_a), .epoch_start(es_a)
  );

  plab4_net_sd_scheduler #(
    .p_cnt_nbits(8), .p_epoch_len_0(0), .p_epoch_len_1(1), .p_dead_cycles(0)
  ) dut_b (
    .clk(clk), .reset(rst_b),
`ifdef PLAB4_NET_SD_SCHED_CFG_EN
    .cfg_val(1'b0), .cfg_sd(1'b0), .cfg_len(8'd0), .cfg_rdy(cfg_rdy_b),
`endif
    .in_sd(in_sd_b), .cur_sd(cur_sd_b), .inj_allow(inj_b),
    .phase(phase_b), .epoch_start(es_b)
  );

  typedef struct {
    logic [3:0] in_sd;
    logic       cur_sd;
    logic       phase;
    logic       es;
    logic [3:0] inj;
  } vec_t;

  vec_t tbl [16];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic step_a();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step_a();
  endtask

  task automatic reset_a();
    rst_a   = 1'b1;
    cfg_val = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    cyc   = 0;
  endtask

  task automatic cfg_write(input logic sd, input logic [7:0] len);
    cfg_val = 1'b1;
    cfg_sd  = sd;
    cfg_len = len;
    step_a();
    cfg_val = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b1010, 1'b0, 1'b0, 1'b1, 4'b0101};
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111};
    tbl[2]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[3]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 4'b0101};
    tbl[4]  = '{4'b1010, 1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[5]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[6]  = '{4'b1010, 1'b1, 1'b0, 1'b1, 4'b1010};
    tbl[7]  = '{4'b0110, 1'b1, 1'b0, 1'b0, 4'b0110};
    tbl[8]  = '{4'b1010, 1'b1, 1'b0, 1'b0, 4'b1010};
    tbl[9]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001};
    tbl[10] = '{4'b1010, 1'b1, 1'b0, 1'b0, 4'b1010};
    tbl[11] = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b1111};
    tbl[12] = '{4'b1010, 1'b1, 1'b1, 1'b0, 4'b0000};
    tbl[13] = '{4'b1111, 1'b1, 1'b1, 1'b0, 4'b0000};
    tbl[14] = '{4'b1010, 1'b0, 1'b0, 1'b1, 4'b0101};
    tbl[15] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111};

    rst_a   = 1'b1;
    rst_b   = 1'b1;
    in_sd_a = 4'b1010;
    in_sd_b = 4'b1100;
    cfg_val = 1'b0;
    cfg_sd  = 1'b0;
    cfg_len = 8'd0;
    @(posedge clk);
    #1;

    // Full schedule period for len0=4, len1=6, dead=2
    reset_a();
    for (int i = 0; i < 16; i++) begin
      in_sd_a = tbl[i].in_sd;
      #1;
      chk("cur_sd",      i, 32'(cur_sd_a), 32'(tbl[i].cur_sd));
      chk("phase",       i, 32'(phase_a),  32'(tbl[i].phase));
      chk("epoch_start", i, 32'(es_a),     32'(tbl[i].es));
      chk("inj_allow",   i, 32'(inj_a),    32'(tbl[i].inj));
      step_a();
    end
    in_sd_a = 4'b1010;

    // dead=0 with len0=0 (clamped) and len1=1: domain toggles every cycle
    rst_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("b_cur_sd",      k, 32'(cur_sd_b), 32'(k % 2));
      chk("b_epoch_start", k, 32'(es_b),     32'd1);
      chk("b_phase",       k, 32'(phase_b),  32'd0);
      chk("b_inj_allow",   k, 32'(inj_b),    (k % 2 == 1) ? 32'hC : 32'h3);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of the dead window
    reset_a();
    run_to(5);
    chk("rstd_pre_phase", cyc, 32'(phase_a), 32'd1);
    rst_a = 1'b1;
    step_a();
    chk("rstd_cur_sd", cyc, 32'(cur_sd_a), 32'd0);
    chk("rstd_phase",  cyc, 32'(phase_a),  32'd0);
    chk("rstd_es",     cyc, 32'(es_a),     32'd1);
    chk("rstd_inj",    cyc, 32'(inj_a),    32'h5);
    rst_a = 1'b0;
    cyc   = 0;
    run_to(3);
    chk("rstd_c3_phase", cyc, 32'(phase_a), 32'd0);
    run_to(4);
    chk("rstd_c4_phase", cyc, 32'(phase_a), 32'd1);
    run_to(6);
    chk("rstd_c6_cur_sd", cyc, 32'(cur_sd_a), 32'd1);
    chk("rstd_c6_es",     cyc, 32'(es_a),     32'd1);

    // Reset in the middle of a domain 1 epoch
    run_to(8);
    chk("rste_pre_cur_sd", cyc, 32'(cur_sd_a), 32'd1);
    rst_a = 1'b1;
    step_a();
    chk("rste_cur_sd", cyc, 32'(cur_sd_a), 32'd0);
    chk("rste_es",     cyc, 32'(es_a),     32'd1);
    rst_a = 1'b0;

`ifdef PLAB4_NET_SD_SCHED_CFG_EN
    // Shortening domain 1 ahead of its epoch
    reset_a();
    chk("cfg_rdy", cyc, 32'(cfg_rdy_a), 32'd1);
    run_to(3);
    cfg_write(1'b1, 8'd2);
    run_to(6);
    chk("cfga_c6_cur_sd", cyc, 32'(cur_sd_a), 32'd1);
    chk("cfga_c6_es",     cyc, 32'(es_a),     32'd1);
    run_to(7);
    chk("cfga_c7_phase", cyc, 32'(phase_a), 32'd0);
    run_to(8);
    chk("cfga_c8_phase", cyc, 32'(phase_a), 32'd1);
    run_to(10);
    chk("cfga_c10_cur_sd", cyc, 32'(cur_sd_a), 32'd0);
    chk("cfga_c10_es",     cyc, 32'(es_a),     32'd1);

    // Zero length clamps to a single active cycle
    reset_a();
    run_to(1);
    cfg_write(1'b0, 8'd0);
    run_to(14);
    chk("cfgb_c14_cur_sd", cyc, 32'(cur_sd_a), 32'd0);
    chk("cfgb_c14_phase",  cyc, 32'(phase_a),  32'd0);
    run_to(15);
    chk("cfgb_c15_phase", cyc, 32'(phase_a), 32'd1);
    run_to(17);
    chk("cfgb_c17_cur_sd", cyc, 32'(cur_sd_a), 32'd1);
    chk("cfgb_c17_es",     cyc, 32'(es_a),     32'd1);

    // Write on the entry edge keeps the old length for the current epoch
    reset_a();
    run_to(5);
    cfg_write(1'b1, 8'd2);
    chk("cfgc_c6_cur_sd", cyc, 32'(cur_sd_a), 32'd1);
    run_to(11);
    chk("cfgc_c11_phase", cyc, 32'(phase_a), 32'd0);
    run_to(12);
    chk("cfgc_c12_phase", cyc, 32'(phase_a), 32'd1);
    run_to(20);
    chk("cfgc_c20_cur_sd", cyc, 32'(cur_sd_a), 32'd1);
    chk("cfgc_c20_es",     cyc, 32'(es_a),     32'd1);
    run_to(21);
    chk("cfgc_c21_phase", cyc, 32'(phase_a), 32'd0);
    run_to(22);
    chk("cfgc_c22_phase", cyc, 32'(phase_a), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
